// File: rtl/arb_req_agent_pkg.sv
// rtl/arb_req_agent_pkg.sv - shared definitions for the arbiter request agent
//
// Purpose : default sizes, grant-id width helper, grant legality rule and
//           the per-client counter action decode. The legality rule lives
//           here so the arbiter bench can apply the same definition.
// Ports   : none (package)
package arb_req_agent_pkg;

  localparam int REQ_WIDTH_DEF = 8;
  localparam int CNT_WIDTH_DEF = 4;

  // Binary grant-index width; never below 1 bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // A grant is legal when it names exactly one client and that client has work.
  function automatic logic grant_legal(input logic is_onehot, input logic req_hit);
    return is_onehot & req_hit;
  endfunction

  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2
  } cnt_action_e;

  // Accepted push and legal grant cancel each other.
  function automatic cnt_action_e cnt_action(input logic p, input logic g);
    cnt_action_e a;
    a = CNT_HOLD;
    if (p && !g) a = CNT_INC;
    if (!p && g) a = CNT_DEC;
    return a;
  endfunction

endpackage

// File: rtl/arb_req_agent_onehot_enc.sv
// rtl/arb_req_agent_onehot_enc.sv - one-hot to binary encoder with one-hot flag
//
// Purpose : converts a grant vector to a binary index and reports whether
//           exactly one bit is set.
// Ports   : vec       in  WIDTH  candidate one-hot vector
//           id        out ID_W   binary index (valid only when is_onehot)
//           is_onehot out 1      exactly one bit of vec is set
module arb_req_agent_onehot_enc #(
  parameter int WIDTH = 8,
  parameter int ID_W  = 3
) (
  input  logic [WIDTH-1:0] vec,
  output logic [ID_W-1:0]  id,
  output logic             is_onehot
);

  logic [WIDTH-1:0] one;

  assign one = {{(WIDTH-1){1'b0}}, 1'b1};

  // OR of indices of set bits: exact for one-hot input, don't-care otherwise.
  always_comb begin
    id = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i]) id = id | ID_W'(i);
    end
  end

  // Clearing the lowest set bit leaves zero only for a single-bit vector.
  assign is_onehot = (vec != '0) && ((vec & (vec - one)) == '0);

endmodule

// File: rtl/arb_req_agent.sv
// rtl/arb_req_agent.sv - per-client pending counters driving a priority arbiter
//
// Purpose : counts pushed requests per client, presents req to the arbiter,
//           consumes legal one-hot grants and reports them as a registered
//           binary id; flags dropped pushes and illegal grants.
// Ports   : clk        in  1          rising-edge clock
//           rst        in  1          synchronous active-high reset
//           push       in  REQ_WIDTH  one request per set bit
//           full       out REQ_WIDTH  client counter at maximum
//           req        out REQ_WIDTH  client has pending work (to arbiter)
//           gnt        in  REQ_WIDTH  arbiter grant, one-hot or zero
//           gnt_valid  out 1          pulse: legal grant consumed last cycle
//           gnt_id     out ID_WIDTH   index of that grant
//           drop       out 1          pulse: a push hit a full counter
//           err        out 1          sticky illegal-grant flag
module arb_req_agent
  import arb_req_agent_pkg::*;
#(
  parameter int REQ_WIDTH = REQ_WIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF,
  localparam int ID_WIDTH = id_width(REQ_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REQ_WIDTH-1:0] push,
  output logic [REQ_WIDTH-1:0] full,
  output logic [REQ_WIDTH-1:0] req,
  input  logic [REQ_WIDTH-1:0] gnt,
  output logic                 gnt_valid,
  output logic [ID_WIDTH-1:0]  gnt_id,
  output logic                 drop,
  output logic                 err
);

  logic [ID_WIDTH-1:0]  enc_id;
  logic                 gnt_onehot;
  logic                 gnt_ok;
  logic                 gnt_bad;
  logic [REQ_WIDTH-1:0] gnt_take;
  logic [REQ_WIDTH-1:0] push_lost;

  arb_req_agent_onehot_enc #(
    .WIDTH (REQ_WIDTH),
    .ID_W  (ID_WIDTH)
  ) u_enc (
    .vec       (gnt),
    .id        (enc_id),
    .is_onehot (gnt_onehot)
  );

  assign gnt_ok   = grant_legal(gnt_onehot, |(gnt & req));
  assign gnt_bad  = (gnt != '0) && !gnt_ok;
  assign gnt_take = gnt & {REQ_WIDTH{gnt_ok}};

  // A full client that is granted in the same cycle still takes the push:
  // the grant frees the slot the push fills, so the count holds at max.
  assign push_lost = push & full & ~gnt_take;

  for (genvar i = 0; i < REQ_WIDTH; i++) begin : g_slice
    logic [CNT_WIDTH-1:0] cnt;
    logic                 p;
    logic                 g;

    assign g = gnt_take[i];
    assign p = push[i] & (~full[i] | g);

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt <= '0;
      end else begin
        case (cnt_action(p, g))
          CNT_INC: cnt <= cnt + 1'b1;
          CNT_DEC: cnt <= cnt - 1'b1;
          default: cnt <= cnt;
        endcase
      end
    end

    assign req[i]  = (cnt != '0);
    assign full[i] = &cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      drop      <= 1'b0;
      err       <= 1'b0;
    end else begin
      gnt_valid <= gnt_ok;
      if (gnt_ok) gnt_id <= enc_id;
      drop      <= |push_lost;
      err       <= err | gnt_bad;
    end
  end

endmodule

// File: tb/tb_arb_req_agent.sv
// tb/tb_arb_req_agent.sv - directed bench for arb_req_agent
module tb_arb_req_agent;

  logic       clk;
  logic       rst;
  logic [7:0] push;
  logic [7:0] full;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [7:0] gnt_drv;
  logic [7:0] arb_gnt;
  logic       arb_on;
  logic       gnt_valid;
  logic [2:0] gnt_id;
  logic       drop;
  logic       err;

  int checks;
  int failures;

  arb_req_agent dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .full      (full),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .drop      (drop),
    .err       (err)
  );

  // Lowest-index-first priority arbiter used for the closed-loop test.
  assign arb_gnt = req & (~req + 8'd1);
  assign gnt     = arb_on ? arb_gnt : gnt_drv;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; push = 8'h00; gnt_drv = 8'h00;
    tick();
    rst = 1'b0;
  endtask

  task automatic load(input logic [7:0] p, input int n);
    for (int k = 0; k < n; k++) begin
      push = p;
      tick();
    end
    push = 8'h00;
  endtask

  task automatic drain_client(input int idx, output int n);
    n = 0;
    while (req[idx] && n < 40) begin
      gnt_drv = 8'h01 << idx;
      tick();
      n++;
    end
    gnt_drv = 8'h00;
  endtask

  task automatic test_reset();
    arb_on = 1'b0;
    do_reset();
    checks++; if (req !== 8'h00) begin failures++; $display("FAIL reset_req got=%h exp=00", req); end
    checks++; if (full !== 8'h00) begin failures++; $display("FAIL reset_full got=%h exp=00", full); end
    checks++; if (gnt_valid !== 1'b0) begin failures++; $display("FAIL reset_gnt_valid got=%b exp=0", gnt_valid); end
    checks++; if (gnt_id !== 3'd0) begin failures++; $display("FAIL reset_gnt_id got=%0d exp=0", gnt_id); end
    checks++; if (drop !== 1'b0) begin failures++; $display("FAIL reset_drop got=%b exp=0", drop); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
  endtask

  task automatic test_single_push();
    do_reset();
    push = 8'h01;
    tick();
    push = 8'h00;
    checks++; if (req !== 8'h01) begin failures++; $display("FAIL single_req_rise got=%h exp=01", req); end
    gnt_drv = 8'h01;
    tick();
    gnt_drv = 8'h00;
    checks++; if (gnt_valid !== 1'b1) begin failures++; $display("FAIL single_gnt_valid got=%b exp=1", gnt_valid); end
    checks++; if (gnt_id !== 3'd0) begin failures++; $display("FAIL single_gnt_id got=%0d exp=0", gnt_id); end
    checks++; if (req !== 8'h00) begin failures++; $display("FAIL single_req_fall got=%h exp=00", req); end
    tick();
    checks++; if (gnt_valid !== 1'b0) begin failures++; $display("FAIL single_gnt_pulse got=%b exp=0", gnt_valid); end
  endtask

  task automatic test_saturation();
    int drops;
    int n;
    do_reset();
    drops = 0;
    for (int k = 1; k <= 16; k++) begin
      push = 8'h08;
      tick();
      if (drop) drops++;
      if (k == 14) begin
        checks++; if (full !== 8'h00) begin failures++; $display("FAIL sat_full_early got=%h exp=00", full); end
      end
      if (k == 15) begin
        checks++; if (full !== 8'h08) begin failures++; $display("FAIL sat_full_15 got=%h exp=08", full); end
      end
    end
    push = 8'h00;
    tick();
    if (drop) drops++;
    checks++; if (drops !== 1) begin failures++; $display("FAIL sat_drop_count got=%0d exp=1", drops); end
    checks++; if (drop !== 1'b0) begin failures++; $display("FAIL sat_drop_pulse got=%b exp=0", drop); end
    drain_client(3, n);
    checks++; if (n !== 15) begin failures++; $display("FAIL sat_grants_to_clear got=%0d exp=15", n); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL sat_err got=%b exp=0", err); end
  endtask

  task automatic test_full_push_grant();
    int n;
    do_reset();
    load(8'h02, 15);
    checks++; if (full !== 8'h02) begin failures++; $display("FAIL fpg_full_before got=%h exp=02", full); end
    push = 8'h02; gnt_drv = 8'h02;
    tick();
    push = 8'h00; gnt_drv = 8'h00;
    checks++; if (full !== 8'h02) begin failures++; $display("FAIL fpg_full_after got=%h exp=02", full); end
    checks++; if (drop !== 1'b0) begin failures++; $display("FAIL fpg_drop got=%b exp=0", drop); end
    checks++; if (gnt_valid !== 1'b1 || gnt_id !== 3'd1) begin failures++; $display("FAIL fpg_grant got=%b/%0d exp=1/1", gnt_valid, gnt_id); end
    drain_client(1, n);
    checks++; if (n !== 15) begin failures++; $display("FAIL fpg_grants_to_clear got=%0d exp=15", n); end
  endtask

  task automatic test_push_grant_same();
    do_reset();
    load(8'h20, 1);
    checks++; if (req !== 8'h20) begin failures++; $display("FAIL pg_req_before got=%h exp=20", req); end
    push = 8'h20; gnt_drv = 8'h20;
    tick();
    push = 8'h00; gnt_drv = 8'h00;
    checks++; if (gnt_valid !== 1'b1) begin failures++; $display("FAIL pg_gnt_valid got=%b exp=1", gnt_valid); end
    checks++; if (gnt_id !== 3'd5) begin failures++; $display("FAIL pg_gnt_id got=%0d exp=5", gnt_id); end
    checks++; if (req !== 8'h20) begin failures++; $display("FAIL pg_req_hold got=%h exp=20", req); end
    gnt_drv = 8'h20;
    tick();
    gnt_drv = 8'h00;
    checks++; if (req !== 8'h00) begin failures++; $display("FAIL pg_count_one got=%h exp=00", req); end
  endtask

  task automatic test_illegal();
    do_reset();
    load(8'h06, 1);
    gnt_drv = 8'h80;
    tick();
    gnt_drv = 8'h00;
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL ill_zero_err got=%b exp=1", err); end
    checks++; if (gnt_valid !== 1'b0) begin failures++; $display("FAIL ill_zero_gnt_valid got=%b exp=0", gnt_valid); end
    checks++; if (req !== 8'h06) begin failures++; $display("FAIL ill_zero_req got=%h exp=06", req); end

    do_reset();
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL ill_reset_clear got=%b exp=0", err); end
    load(8'h06, 1);
    gnt_drv = 8'h06;
    tick();
    gnt_drv = 8'h00;
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL ill_multi_err got=%b exp=1", err); end
    checks++; if (gnt_valid !== 1'b0) begin failures++; $display("FAIL ill_multi_gnt_valid got=%b exp=0", gnt_valid); end
    checks++; if (req !== 8'h06) begin failures++; $display("FAIL ill_multi_req got=%h exp=06", req); end
    tick();
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL ill_sticky got=%b exp=1", err); end
    gnt_drv = 8'h02;
    tick();
    gnt_drv = 8'h00;
    checks++; if (gnt_valid !== 1'b1 || gnt_id !== 3'd1) begin failures++; $display("FAIL ill_then_legal got=%b/%0d exp=1/1", gnt_valid, gnt_id); end
    checks++; if (req !== 8'h04) begin failures++; $display("FAIL ill_then_legal_req got=%h exp=04", req); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    push = 8'h45; tick();
    push = 8'h05; tick();
    push = 8'h04; tick();
    push = 8'h04; tick();
    push = 8'h00;
    checks++; if (req !== 8'h45) begin failures++; $display("FAIL rmid_loaded got=%h exp=45", req); end
    rst = 1'b1; push = 8'hFF; gnt_drv = 8'h01;
    tick();
    rst = 1'b0; push = 8'h00; gnt_drv = 8'h00;
    checks++; if (req !== 8'h00 || full !== 8'h00) begin failures++; $display("FAIL rmid_req_full got=%h/%h exp=00/00", req, full); end
    checks++; if (gnt_valid !== 1'b0 || gnt_id !== 3'd0 || drop !== 1'b0 || err !== 1'b0) begin
      failures++; $display("FAIL rmid_flags got=%b/%0d/%b/%b exp=0/0/0/0", gnt_valid, gnt_id, drop, err);
    end
    tick();
    checks++; if (req !== 8'h00) begin failures++; $display("FAIL rmid_push_ignored got=%h exp=00", req); end
  endtask

  task automatic test_closed_loop();
    int mcnt[8];
    int accepted;
    int gv;
    int mism;
    int gidx;
    int drained;
    logic [7:0] mreq;
    logic pi;
    logic gi;
    do_reset();
    for (int i = 0; i < 8; i++) mcnt[i] = 0;
    accepted = 0; gv = 0; mism = 0; drained = 0;
    arb_on = 1'b1;
    for (int c = 0; c < 1200; c++) begin
      push = (c < 1000) ? 8'($urandom) : 8'h00;
      gidx = -1;
      for (int i = 7; i >= 0; i--) if (mcnt[i] != 0) gidx = i;
      for (int i = 0; i < 8; i++) begin
        gi = (gidx == i);
        pi = push[i] && (mcnt[i] != 15 || gi);
        if (pi) accepted++;
        if (pi && !gi) mcnt[i]++;
        if (!pi && gi) mcnt[i]--;
      end
      tick();
      if (gnt_valid) gv++;
      for (int i = 0; i < 8; i++) mreq[i] = (mcnt[i] != 0);
      if (req !== mreq) mism++;
      if (c >= 1000 && mreq == 8'h00 && req === 8'h00) begin
        drained = 1;
        break;
      end
    end
    push = 8'h00;
    arb_on = 1'b0;
    tick();
    if (gnt_valid) gv++;
    checks++; if (drained !== 1) begin failures++; $display("FAIL cl_drain_timeout req=%h", req); end
    checks++; if (mism !== 0) begin failures++; $display("FAIL cl_req_track got=%0d exp=0 mismatching cycles", mism); end
    checks++; if (gv !== accepted) begin failures++; $display("FAIL cl_grant_count got=%0d exp=%0d", gv, accepted); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL cl_err got=%b exp=0", err); end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; push = 8'h00; gnt_drv = 8'h00; arb_on = 1'b0;
    test_reset();
    test_single_push();
    test_saturation();
    test_full_push_grant();
    test_push_grant_same();
    test_illegal();
    test_reset_mid();
    test_closed_loop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arb_req_agent.md
# arb_req_agent

Request-side companion to the team's `priority_arbiter` (`REQ_WIDTH` request lines in, one-hot `gnt` out). It collects transfer requests from `REQ_WIDTH` clients, keeps a per-client pending count, and drives the arbiter's `req` vector while work is pending. It consumes the arbiter's `gnt` and reports each grant to downstream logic as a registered binary client ID. It sits between the client push interfaces and the arbiter input, and checks that the arbiter behaves legally.

## Interface
- `REQ_WIDTH`, 8, number of clients (and width of the arbiter request/grant vectors); must be ≥ 2.
- `CNT_WIDTH`, 4, width of each per-client pending counter; maximum pending per client is 2^CNT_WIDTH−1.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `push`  in  REQ_WIDTH  bit i = client i submits one request this cycle.
- `full`  out  REQ_WIDTH  bit i = client i's counter is at maximum; a push is dropped.
- `req`  out  REQ_WIDTH  to the arbiter; bit i = client i count ≠ 0.
- `gnt`  in  REQ_WIDTH  from the arbiter; must be one-hot or zero.
- `gnt_valid`  out  1  one-cycle pulse, a legal grant was consumed.
- `gnt_id`  out  ID_WIDTH  binary index of the granted client; qualified by `gnt_valid`.
- `drop`  out  1  one-cycle pulse, at least one push was lost to a full counter.
- `err`  out  1  sticky, illegal grant seen; cleared only by `rst`.

## Operation
- Each client i has a counter `cnt[i]` of `CNT_WIDTH` bits.
- Outputs derived combinationally from the counter registers:
  - `req[i] = (cnt[i] != 0)`
  - `full[i] = (cnt[i] == max)`
- A grant is legal when `gnt` is one-hot and `req[gnt index] == 1`.
- Counter update per cycle, with `p = push[i] & ~full[i]` and `g = legal grant to i`:
  - p & ~g: increment.
  - ~p & g: decrement.
  - p & g, or neither: hold.
- A push and a grant on the same client in the same cycle leave the count unchanged, including when the count is at max.
- Push to a full client: the push is dropped, the count stays at max, and `drop` pulses in the next cycle.
- Illegal grant (multi-hot, or a grant to a client with `cnt == 0`):
  - No counter decrements.
  - `gnt_valid` stays low.
  - `err` sets in the next cycle and stays high.
- `gnt == 0` is idle and is not an error.
- Reset values: all counters 0, so `req = 0` and `full = 0`. `gnt_valid = 0`, `gnt_id = 0`, `drop = 0`, `err = 0`.
- Reset asserted mid-operation discards all pending counts. Any `push` or `gnt` in a reset cycle is ignored.

## Timing
- Push to `req` rising: 1 cycle. A push sampled at edge N appears on `req` after edge N.
- `gnt` sampled at edge N → `gnt_valid` and `gnt_id` registered, visible after edge N for exactly one cycle.
- Latest grant to `req` falling: 1 cycle, when the count goes from 1 to 0.
- Back-to-back grants to the same client are legal every cycle while its count is > 0.
- `full` and `req` have no register stage beyond the counters. The arbiter path `req → gnt` is combinational, so `gnt` must be a function of the current `req`.

## Structure
- Shared header `arb_defs.vh` holds:
  - the `REQ_WIDTH` default;
  - `ID_WIDTH = $clog2(REQ_WIDTH)`;
  - the legal-grant check as a macro or function, shared with the arbiter bench.
- One sub-module, `onehot_enc`:
  - one-hot → binary, producing `id` and an `is_onehot` flag;
  - used for `gnt_id` and for the legality check.
- Counters are a generate loop of `REQ_WIDTH` identical slices in the top module.

## Test plan
- Single push:
  - Stimulus: `push = 8'h01` for one cycle, then `gnt = 8'h01` once `req[0]` is high.
  - Required: `req = 8'h01` one cycle after the push; `gnt_valid` = 1 with `gnt_id` = 0; `req` back to 0 one cycle after the grant.
- Saturation (`CNT_WIDTH = 4`):
  - Stimulus: 16 consecutive pushes on client 3.
  - Required: `full[3]` = 1 after the 15th push; `drop` pulses once, for the 16th; 15 grants are then needed to clear `req[3]`.
- Simultaneous push and grant on client 5 at count 1:
  - Required: count stays 1, `req[5]` stays high, `gnt_valid` = 1 with `gnt_id` = 5.
- Illegal grants:
  - Stimulus: `gnt = 8'h06`, or `gnt = 8'h80` while `cnt[7] = 0`.
  - Required: `err` = 1 one cycle later and stays 1; counts unchanged; no `gnt_valid`.
- Reset mid-operation:
  - Stimulus: load counts 2, 4 and 1 on clients 0, 2 and 6, then assert `rst` for one cycle together with `push = 8'hFF`.
  - Required: all outputs at their reset values, `req = 0`.
- Closed loop with `priority_arbiter`:
  - Stimulus: random pushes for 1000 cycles, then no pushes until `req = 0`.
  - Required: total `gnt_valid` count = accepted pushes; `err` = 0.
